// File: rtl/result_checker.sv
// In-order scoreboard: buffers expected and actual result streams, pairs their heads,
// and emits one registered compare event per pair with step and pass/fail counters.
module result_checker #(
  parameter int unsigned WORD   = 64,
  parameter int unsigned BITS_W = 7,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              exp_valid_i,
  input  logic [WORD-1:0]   exp_data_i,
  input  logic [BITS_W-1:0] exp_bits_i,
  output logic              exp_ready_o,
  input  logic              act_valid_i,
  input  logic [WORD-1:0]   act_data_i,
  input  logic [BITS_W-1:0] act_bits_i,
  output logic              act_ready_o,
  output logic              out_valid_o,
  output logic [WORD-1:0]   out_cr_o,
  output logic [WORD-1:0]   out_ar_o,
  output logic              out_pass_o,
  output logic [CNT_W-1:0]  out_step_o,
  output logic [CNT_W-1:0]  pass_count_o,
  output logic [CNT_W-1:0]  fail_count_o,
  output logic              overflow_o,
  output logic              pending_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = WORD + BITS_W;
  localparam logic [AW:0]      PtrOne = (AW + 1)'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Each entry holds {data, bits} so one equality compare covers both fields.
  logic [EW-1:0] exp_mem_q [DEPTH];
  logic [EW-1:0] act_mem_q [DEPTH];

  logic [AW:0] exp_wptr_q, exp_wptr_d, exp_rptr_q, exp_rptr_d;
  logic [AW:0] act_wptr_q, act_wptr_d, act_rptr_q, act_rptr_d;

  logic              out_valid_q, out_valid_d;
  logic [WORD-1:0]   out_cr_q, out_cr_d;
  logic [WORD-1:0]   out_ar_q, out_ar_d;
  logic              out_pass_q, out_pass_d;
  logic [CNT_W-1:0]  out_step_q, out_step_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]  next_step_q, next_step_d;
  logic              overflow_q, overflow_d;

  logic          exp_full, exp_empty, act_full, act_empty;
  logic          exp_push, act_push, pop;
  logic [EW-1:0] exp_head, act_head;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign exp_full  = (exp_wptr_q[AW] != exp_rptr_q[AW]) &&
                     (exp_wptr_q[AW-1:0] == exp_rptr_q[AW-1:0]);
  assign act_full  = (act_wptr_q[AW] != act_rptr_q[AW]) &&
                     (act_wptr_q[AW-1:0] == act_rptr_q[AW-1:0]);
  assign exp_empty = (exp_wptr_q == exp_rptr_q);
  assign act_empty = (act_wptr_q == act_rptr_q);

  assign exp_push = exp_valid_i && !exp_full && !clear_i;
  assign act_push = act_valid_i && !act_full && !clear_i;
  assign pop      = !exp_empty && !act_empty && !clear_i;

  assign exp_head = exp_mem_q[exp_rptr_q[AW-1:0]];
  assign act_head = act_mem_q[act_rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (exp_push) exp_mem_q[exp_wptr_q[AW-1:0]] <= {exp_data_i, exp_bits_i};
    if (act_push) act_mem_q[act_wptr_q[AW-1:0]] <= {act_data_i, act_bits_i};
  end

  always_comb begin
    exp_wptr_d  = exp_wptr_q;
    exp_rptr_d  = exp_rptr_q;
    act_wptr_d  = act_wptr_q;
    act_rptr_d  = act_rptr_q;
    out_valid_d = 1'b0;
    out_cr_d    = out_cr_q;
    out_ar_d    = out_ar_q;
    out_pass_d  = out_pass_q;
    out_step_d  = out_step_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    next_step_d = next_step_q;
    overflow_d  = overflow_q;

    if (clear_i) begin
      // Event payload registers are intentionally held across a flush.
      exp_wptr_d  = '0;
      exp_rptr_d  = '0;
      act_wptr_d  = '0;
      act_rptr_d  = '0;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      next_step_d = CntOne;
      overflow_d  = 1'b0;
    end else begin
      if (exp_push) exp_wptr_d = exp_wptr_q + PtrOne;
      if (act_push) act_wptr_d = act_wptr_q + PtrOne;
      if ((exp_valid_i && exp_full) || (act_valid_i && act_full)) overflow_d = 1'b1;
      if (pop) begin
        exp_rptr_d  = exp_rptr_q + PtrOne;
        act_rptr_d  = act_rptr_q + PtrOne;
        out_valid_d = 1'b1;
        out_cr_d    = exp_head[EW-1:BITS_W];
        out_ar_d    = act_head[EW-1:BITS_W];
        out_pass_d  = (exp_head == act_head);
        out_step_d  = next_step_q;
        next_step_d = next_step_q + CntOne;
        if (exp_head == act_head) pass_cnt_d = pass_cnt_q + CntOne;
        else                      fail_cnt_d = fail_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_wptr_q  <= '0;
      exp_rptr_q  <= '0;
      act_wptr_q  <= '0;
      act_rptr_q  <= '0;
      out_valid_q <= 1'b0;
      out_cr_q    <= '0;
      out_ar_q    <= '0;
      out_pass_q  <= 1'b0;
      out_step_q  <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      next_step_q <= CntOne;
      overflow_q  <= 1'b0;
    end else begin
      exp_wptr_q  <= exp_wptr_d;
      exp_rptr_q  <= exp_rptr_d;
      act_wptr_q  <= act_wptr_d;
      act_rptr_q  <= act_rptr_d;
      out_valid_q <= out_valid_d;
      out_cr_q    <= out_cr_d;
      out_ar_q    <= out_ar_d;
      out_pass_q  <= out_pass_d;
      out_step_q  <= out_step_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      next_step_q <= next_step_d;
      overflow_q  <= overflow_d;
    end
  end

  assign exp_ready_o  = !exp_full;
  assign act_ready_o  = !act_full;
  assign out_valid_o  = out_valid_q;
  assign out_cr_o     = out_cr_q;
  assign out_ar_o     = out_ar_q;
  assign out_pass_o   = out_pass_q;
  assign out_step_o   = out_step_q;
  assign pass_count_o = pass_cnt_q;
  assign fail_count_o = fail_cnt_q;
  assign overflow_o   = overflow_q;
  assign pending_o    = !exp_empty || !act_empty;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the scoreboard.
module tb_result_checker;

  localparam int unsigned WORD   = 64;
  localparam int unsigned BITS_W = 7;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 5;  // narrow so random traffic wraps the counters

  typedef logic [WORD+BITS_W-1:0] ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              exp_valid = 1'b0;
  logic [WORD-1:0]   exp_data = '0;
  logic [BITS_W-1:0] exp_bits = '0;
  logic              exp_ready;
  logic              act_valid = 1'b0;
  logic [WORD-1:0]   act_data = '0;
  logic [BITS_W-1:0] act_bits = '0;
  logic              act_ready;
  logic              out_valid;
  logic [WORD-1:0]   out_cr, out_ar;
  logic              out_pass;
  logic [CNT_W-1:0]  out_step, pass_count, fail_count;
  logic              overflow, pending;

  result_checker #(.WORD(WORD), .BITS_W(BITS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .exp_valid_i  (exp_valid),
    .exp_data_i   (exp_data),
    .exp_bits_i   (exp_bits),
    .exp_ready_o  (exp_ready),
    .act_valid_i  (act_valid),
    .act_data_i   (act_data),
    .act_bits_i   (act_bits),
    .act_ready_o  (act_ready),
    .out_valid_o  (out_valid),
    .out_cr_o     (out_cr),
    .out_ar_o     (out_ar),
    .out_pass_o   (out_pass),
    .out_step_o   (out_step),
    .pass_count_o (pass_count),
    .fail_count_o (fail_count),
    .overflow_o   (overflow),
    .pending_o    (pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  ent_t             m_exp[$];
  ent_t             m_act[$];
  logic             m_valid, m_pass, m_ovf;
  logic [WORD-1:0]  m_cr, m_ar;
  logic [CNT_W-1:0] m_step, m_pc, m_fc, m_next;

  task automatic check(input string tag, input logic [WORD-1:0] got,
                       input logic [WORD-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_exp.delete();
    m_act.delete();
    m_valid = 0; m_pass = 0; m_ovf = 0;
    m_cr = '0; m_ar = '0;
    m_step = '0; m_pc = '0; m_fc = '0; m_next = 1;
  endtask

  task automatic model_edge();
    int ne, na;
    ent_t e, a;
    if (clear) begin
      m_exp.delete();
      m_act.delete();
      m_valid = 0; m_pc = '0; m_fc = '0; m_next = 1; m_ovf = 0;
      return;
    end
    ne = m_exp.size();
    na = m_act.size();
    if (exp_valid && ne == DEPTH) m_ovf = 1;
    if (act_valid && na == DEPTH) m_ovf = 1;
    m_valid = (ne > 0) && (na > 0);
    if (m_valid) begin
      e = m_exp.pop_front();
      a = m_act.pop_front();
      m_cr   = e[WORD+BITS_W-1:BITS_W];
      m_ar   = a[WORD+BITS_W-1:BITS_W];
      m_pass = (m_cr == m_ar) && (e[BITS_W-1:0] == a[BITS_W-1:0]);
      if (m_pass) m_pc = m_pc + 1'b1;
      else        m_fc = m_fc + 1'b1;
      m_step = m_next;
      m_next = m_next + 1'b1;
    end
    if (exp_valid && ne < DEPTH) m_exp.push_back({exp_data, exp_bits});
    if (act_valid && na < DEPTH) m_act.push_back({act_data, act_bits});
  endtask

  task automatic check_all();
    check("out_valid", out_valid, m_valid);
    check("out_cr", out_cr, m_cr);
    check("out_ar", out_ar, m_ar);
    check("out_pass", out_pass, m_pass);
    check("out_step", out_step, m_step);
    check("pass_count", pass_count, m_pc);
    check("fail_count", fail_count, m_fc);
    check("overflow", overflow, m_ovf);
    check("pending", pending, (m_exp.size() > 0) || (m_act.size() > 0));
    check("exp_ready", exp_ready, m_exp.size() < DEPTH);
    check("act_ready", act_ready, m_act.size() < DEPTH);
  endtask

  task automatic cycle(input logic ev, input logic [WORD-1:0] ed, input logic [BITS_W-1:0] eb,
                       input logic av, input logic [WORD-1:0] ad, input logic [BITS_W-1:0] ab,
                       input logic clr);
    exp_valid = ev; exp_data = ed; exp_bits = eb;
    act_valid = av; act_data = ad; act_bits = ab;
    clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    exp_valid = 0; act_valid = 0; clear = 0;
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [WORD-1:0] ones;
    logic            ev, av, clr;
    logic [WORD-1:0] ed, ad;
    logic [BITS_W-1:0] eb, ab;
    ones = '1;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      check("idle_valid", out_valid, 0);
    end

    // Matching pair: event appears one cycle after the pair lands
    cycle(1, 64'h1234, 7'd64, 1, 64'h1234, 7'd64, 0);
    check("lat_no_bypass", out_valid, 0);
    idle();
    check("match_valid", out_valid, 1);
    check("match_pass", out_pass, 1);
    check("match_step", out_step, 1);
    check("match_pcnt", pass_count, 1);
    idle();
    check("match_strobe", out_valid, 0);

    // Same value, different bit count
    cycle(1, ones, 7'd64, 1, ones, 7'd32, 0);
    idle();
    check("bits_pass", out_pass, 0);
    check("bits_fcnt", fail_count, 1);
    check("bits_step", out_step, 2);
    idle();

    // Skewed streams
    cycle(0, '0, '0, 0, '0, '0, 1);
    for (int i = 1; i <= 4; i++) cycle(1, WORD'(i), 7'd64, 0, '0, '0, 0);
    check("skew_full", exp_ready, 0);
    for (int i = 1; i <= 4; i++) cycle(0, '0, '0, 1, WORD'(i), 7'd64, 0);
    for (int i = 0; i < 3; i++) idle();
    check("skew_pcnt", pass_count, 4);
    check("skew_last_step", out_step, 4);

    // Overflow on the expected FIFO
    cycle(0, '0, '0, 0, '0, '0, 1);
    for (int i = 0; i < 5; i++) cycle(1, WORD'(10 + i), 7'd64, 0, '0, '0, 0);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, WORD'(10 + i), 7'd64, 0);
    for (int i = 0; i < 4; i++) idle();
    check("ovf_events", pass_count, 4);
    check("ovf_drained", pending, 0);

    // Clear mid-stream
    cycle(1, 64'h77, 7'd8, 0, '0, '0, 0);
    cycle(1, 64'h78, 7'd8, 0, '0, '0, 0);
    cycle(0, '0, '0, 0, '0, '0, 1);
    check("clr_pending", pending, 0);
    check("clr_pcnt", pass_count, 0);
    check("clr_ovf", overflow, 0);
    cycle(1, 64'h55, 7'd8, 1, 64'h55, 7'd8, 0);
    idle();
    check("clr_step", out_step, 1);

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      ev  = ($urandom_range(0, 99) < 55);
      av  = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) < 2);
      ed  = ($urandom_range(0, 9) == 0) ? {$urandom(), $urandom()} : WORD'($urandom_range(0, 3));
      ad  = ($urandom_range(0, 9) == 0) ? {$urandom(), $urandom()} : WORD'($urandom_range(0, 3));
      eb  = ($urandom_range(0, 7) == 0) ? 7'd32 : 7'd64;
      ab  = ($urandom_range(0, 7) == 0) ? 7'd32 : 7'd64;
      cycle(ev, ed, eb, av, ad, ab, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
